// File: rtl/i2c_master_byte_fsm.sv
// i2c_master_byte_fsm: byte-level I2C master sequencer.
// Steps START/address/data/ACK/STOP on the data_clk phase from the clock generator.
module i2c_master_byte_fsm #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_clk,
  input  logic              ena,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] data_wr,
  input  logic              sda_in,
  output logic              sda_drive_low,
  output logic              scl_not_ena,
  output logic              busy,
  output logic [DATA_W-1:0] data_rd,
  output logic              ack_error
);

  localparam int AW    = ADDR_W + 1;
  localparam int DCW   = $clog2(DATA_W);
  localparam int ACW   = $clog2(AW);
  localparam int CNT_W = (DCW > ACW) ? DCW : ACW;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ADR = CNT_W'(ADDR_W);

  typedef enum logic [3:0] {
    READY,
    START,
    COMMAND,
    SLV_ACK1,
    WR,
    RD,
    SLV_ACK2,
    MSTR_ACK,
    STOP
  } state_t;

  state_t            state;
  logic              data_clk_prev;
  logic              sda_int;
  logic              scl_ena;
  logic [CNT_W-1:0]  bit_cnt;
  logic [AW-1:0]     addr_rw;
  logic [DATA_W-1:0] data_tx;
  logic [DATA_W-1:0] data_rx;

  logic             rise;
  logic             fall;
  logic             same;
  logic [CNT_W-1:0] cnt_dec;

  assign rise    = data_clk & ~data_clk_prev;
  assign fall    = ~data_clk & data_clk_prev;
  assign same    = ({addr, rw} == addr_rw);
  assign cnt_dec = bit_cnt - 1'b1;

  // START and STOP hold SDA low while SCL is released high
  assign sda_drive_low = (state == START) || (state == STOP) || !sda_int;
  assign scl_not_ena   = ~scl_ena;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= READY;
      data_clk_prev <= 1'b0;
      busy          <= 1'b0;
      sda_int       <= 1'b1;
      scl_ena       <= 1'b0;
      bit_cnt       <= CNT_MAX;
      addr_rw       <= '0;
      data_tx       <= '0;
      data_rx       <= '0;
      data_rd       <= '0;
      ack_error     <= 1'b0;
    end else begin
      data_clk_prev <= data_clk;
      if (rise) begin
        unique case (state)
          READY: begin
            if (ena) begin
              busy      <= 1'b1;
              addr_rw   <= {addr, rw};
              data_tx   <= data_wr;
              ack_error <= 1'b0;
              state     <= START;
            end else begin
              busy <= 1'b0;
            end
          end
          START: begin
            sda_int <= addr_rw[AW-1];
            bit_cnt <= CNT_ADR;
            state   <= COMMAND;
          end
          COMMAND: begin
            if (bit_cnt == '0) begin
              sda_int <= 1'b1;
              bit_cnt <= CNT_MAX;
              state   <= SLV_ACK1;
            end else begin
              bit_cnt <= cnt_dec;
              sda_int <= addr_rw[cnt_dec];
            end
          end
          SLV_ACK1: begin
            if (addr_rw[0]) begin
              sda_int <= 1'b1;
              state   <= RD;
            end else begin
              sda_int <= data_tx[DATA_W-1];
              state   <= WR;
            end
          end
          WR: begin
            if (bit_cnt == '0) begin
              sda_int <= 1'b1;
              bit_cnt <= CNT_MAX;
              busy    <= 1'b0;
              state   <= SLV_ACK2;
            end else begin
              bit_cnt <= cnt_dec;
              sda_int <= data_tx[cnt_dec];
            end
          end
          SLV_ACK2: begin
            if (ena && same) begin
              busy    <= 1'b1;
              data_tx <= data_wr;
              sda_int <= data_wr[DATA_W-1];
              state   <= WR;
            end else begin
              state <= STOP;
            end
          end
          RD: begin
            if (bit_cnt == '0) begin
              data_rd <= data_rx;
              busy    <= 1'b0;
              bit_cnt <= CNT_MAX;
              sda_int <= ~(ena && same);
              state   <= MSTR_ACK;
            end else begin
              bit_cnt <= cnt_dec;
            end
          end
          MSTR_ACK: begin
            if (ena && same) begin
              busy    <= 1'b1;
              sda_int <= 1'b1;
              state   <= RD;
            end else begin
              state <= STOP;
            end
          end
          STOP: begin
            // release even if a master ACK was left on the line
            busy    <= 1'b0;
            sda_int <= 1'b1;
            state   <= READY;
          end
          default: state <= READY;
        endcase
      end else if (fall) begin
        unique case (state)
          START:    scl_ena <= 1'b1;
          STOP:     scl_ena <= 1'b0;
          SLV_ACK1: if (sda_in) ack_error <= 1'b1;
          SLV_ACK2: if (sda_in) ack_error <= 1'b1;
          RD:       data_rx[bit_cnt] <= sda_in;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_fsm.sv
// tb_i2c_master_byte_fsm: bus-level scoreboard bench for the byte sequencer.
// A line monitor decodes START/byte/STOP and plays the slave side.
module tb_i2c_master_byte_fsm;

  typedef struct {
    int         kind;
    logic [7:0] dat;
    logic       ack;
    logic       err;
    logic [7:0] rd;
  } exp_t;

  localparam int K_START = 0;
  localparam int K_BYTE  = 1;
  localparam int K_STOP  = 2;

  logic       clk;
  logic       rst;
  logic       data_clk;
  logic       ena;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] data_wr;
  logic       sda_in;
  logic       sda_drive_low;
  logic       scl_not_ena;
  logic       busy;
  logic [7:0] data_rd;
  logic       ack_error;

  int tot = 0;
  int bad = 0;

  exp_t expq[$];
  event ph_a, ph_b, ph_rise;

  logic       nack_addr = 1'b0;
  logic [7:0] slave_byte = 8'h00;

  logic       a_sd, a_so, a_line, b_so;
  logic [8:0] sh = '0;
  int         fr_bit = 0;
  int         fr_idx = 0;
  logic       rd_mode = 1'b0;
  logic       in_frame = 1'b0;

  i2c_master_byte_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .data_clk     (data_clk),
    .ena          (ena),
    .addr         (addr),
    .rw           (rw),
    .data_wr      (data_wr),
    .sda_in       (sda_in),
    .sda_drive_low(sda_drive_low),
    .scl_not_ena  (scl_not_ena),
    .busy         (busy),
    .data_rd      (data_rd),
    .ack_error    (ack_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_clk: 4 clk high, 4 clk low; phase events mark sample points
  initial begin
    data_clk = 1'b0;
    forever begin
      repeat (4) @(negedge clk);
      ->ph_b;
      data_clk = 1'b1;
      ->ph_rise;
      repeat (4) @(negedge clk);
      ->ph_a;
      data_clk = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    tot++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic void push(input int k, input logic [7:0] d,
                               input logic a, input logic e,
                               input logic [7:0] r);
    exp_t x;
    x.kind = k;
    x.dat  = d;
    x.ack  = a;
    x.err  = e;
    x.rd   = r;
    expq.push_back(x);
  endfunction

  task automatic got_ev(input int k, input logic [7:0] d, input logic a,
                        input logic e, input logic [7:0] r);
    exp_t x;
    logic ok;
    tot++;
    if (expq.size() == 0) begin
      bad++;
      $display("FAIL ev_extra kind=%0d dat=%h ack=%b", k, d, a);
    end else begin
      x  = expq.pop_front();
      ok = (x.kind == k);
      if (ok && k == K_BYTE) ok = (x.dat === d) && (x.ack === a);
      if (ok && k == K_STOP) ok = (x.err === e) && (x.rd === r);
      if (!ok) begin
        bad++;
        $display("FAIL ev kind=%0d dat=%h ack=%b err=%b rd=%h want kind=%0d dat=%h ack=%b err=%b rd=%h",
                 k, d, a, e, r, x.kind, x.dat, x.ack, x.err, x.rd);
      end
    end
  endtask

  // line monitor + slave: decode each data_clk period, then set sda_in for the next
  initial begin
    sda_in = 1'b1;
    forever begin
      @(ph_a);
      a_sd   = sda_drive_low;
      a_so   = scl_not_ena;
      a_line = ~sda_drive_low & sda_in;
      @(ph_b);
      b_so = scl_not_ena;
      if (a_so && a_sd) begin
        got_ev(K_START, 8'h00, 1'b0, 1'b0, 8'h00);
        in_frame = 1'b1;
        fr_bit   = 0;
        fr_idx   = 0;
        rd_mode  = 1'b0;
      end else if (!a_so && !b_so) begin
        sh = {sh[7:0], a_line};
        fr_bit++;
        if (fr_bit == 9) begin
          got_ev(K_BYTE, sh[8:1], sh[0], 1'b0, 8'h00);
          if (fr_idx == 0) rd_mode = sh[1];
          fr_idx++;
          fr_bit = 0;
        end
      end else if (!a_so && b_so && a_sd) begin
        got_ev(K_STOP, 8'h00, 1'b0, ack_error, data_rd);
        in_frame = 1'b0;
      end else if (a_so && b_so) begin
        in_frame = 1'b0;
      end
      if (!in_frame)
        sda_in = 1'b1;
      else if (fr_bit == 8)
        sda_in = (fr_idx == 0) ? nack_addr : rd_mode;
      else if (fr_idx != 0 && rd_mode)
        sda_in = slave_byte[7-fr_bit];
      else
        sda_in = 1'b1;
    end
  end

  task automatic wait_busy(input logic v, input string nm);
    int n = 0;
    while (busy !== v && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy !== v) begin
      tot++;
      bad++;
      $display("FAIL %s timeout busy=%b want=%b", nm, busy, v);
    end
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    ena     = 1'b0;
    addr    = '0;
    rw      = 1'b0;
    data_wr = '0;
    repeat (3) @(ph_rise);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_sda", sda_drive_low, 0);
    chk("rst_scl", scl_not_ena, 1);
    chk("rst_rd", data_rd, 0);
    chk("rst_err", ack_error, 0);

    // single write 0x5A to 0x50
    addr = 7'h50; rw = 1'b0; data_wr = 8'h5A; ena = 1'b1;
    push(K_START, 8'h00, 1'b0, 1'b0, 8'h00);
    push(K_BYTE, 8'hA0, 1'b0, 1'b0, 8'h00);
    push(K_BYTE, 8'h5A, 1'b0, 1'b0, 8'h00);
    push(K_STOP, 8'h00, 1'b0, 1'b0, 8'h00);
    wait_busy(1'b1, "t1_acc");
    wait_busy(1'b0, "t1_done");
    ena = 1'b0;
    repeat (3) @(ph_rise);

    // single read from 0x23, slave returns 0xC3, master NACKs
    slave_byte = 8'hC3;
    addr = 7'h23; rw = 1'b1; ena = 1'b1;
    push(K_START, 8'h00, 1'b0, 1'b0, 8'h00);
    push(K_BYTE, 8'h47, 1'b0, 1'b0, 8'h00);
    push(K_BYTE, 8'hC3, 1'b1, 1'b0, 8'h00);
    push(K_STOP, 8'h00, 1'b0, 1'b0, 8'hC3);
    wait_busy(1'b1, "t2_acc");
    ena = 1'b0;
    wait_busy(1'b0, "t2_done");
    chk("t2_data_rd", data_rd, 8'hC3);
    chk("t2_nack_sda", sda_drive_low, 0);
    repeat (3) @(ph_rise);

    // two-byte write to 0x3C
    addr = 7'h3C; rw = 1'b0; data_wr = 8'h11; ena = 1'b1;
    push(K_START, 8'h00, 1'b0, 1'b0, 8'h00);
    push(K_BYTE, 8'h78, 1'b0, 1'b0, 8'h00);
    push(K_BYTE, 8'h11, 1'b0, 1'b0, 8'h00);
    push(K_BYTE, 8'h22, 1'b0, 1'b0, 8'h00);
    push(K_STOP, 8'h00, 1'b0, 1'b0, 8'hC3);
    wait_busy(1'b1, "t3_acc");
    wait_busy(1'b0, "t3_b1");
    data_wr = 8'h22;
    n = 0;
    while (busy === 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t3_busy_low_clks", n, 8);
    wait_busy(1'b0, "t3_b2");
    ena = 1'b0;
    repeat (3) @(ph_rise);

    // address NACK: sticky ack_error, transfer continues
    nack_addr = 1'b1;
    addr = 7'h10; rw = 1'b0; data_wr = 8'h99; ena = 1'b1;
    push(K_START, 8'h00, 1'b0, 1'b0, 8'h00);
    push(K_BYTE, 8'h20, 1'b1, 1'b0, 8'h00);
    push(K_BYTE, 8'h99, 1'b0, 1'b0, 8'h00);
    push(K_STOP, 8'h00, 1'b0, 1'b1, 8'hC3);
    wait_busy(1'b1, "t4_acc");
    wait_busy(1'b0, "t4_done");
    chk("t4_err_ack2", ack_error, 1);
    ena = 1'b0;
    repeat (3) @(ph_rise);
    chk("t4_err_idle", ack_error, 1);
    nack_addr = 1'b0;

    // reset in the middle of the data byte
    addr = 7'h50; rw = 1'b0; data_wr = 8'hFF; ena = 1'b1;
    push(K_START, 8'h00, 1'b0, 1'b0, 8'h00);
    push(K_BYTE, 8'hA0, 1'b0, 1'b0, 8'h00);
    wait_busy(1'b1, "t5_acc");
    chk("t5_err_clr", ack_error, 0);
    repeat (12) @(ph_rise);
    rst = 1'b1;
    ena = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_sda", sda_drive_low, 0);
    chk("t5_scl", scl_not_ena, 1);
    chk("t5_err", ack_error, 0);
    chk("t5_rd", data_rd, 0);

    // idle with ena low
    repeat (5) begin
      @(ph_a);
      chk("idle_busy", busy, 0);
      chk("idle_scl", scl_not_ena, 1);
      chk("idle_sda", sda_drive_low, 0);
    end

    repeat (2) @(ph_rise);
    chk("q_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte_fsm.md
Name: i2c_master_byte_fsm

Overview:
- Byte-level I2C master sequencer; sits directly downstream of the i2cStrech clock/stretch generator.
- Consumes its data_clk phase signal and sequences START, address+R/W, write/read bytes, ACK/NACK and STOP on SDA.
- Drives scl_not_ena back upstream so SCL is gated (released high) whenever no transaction is active.
- User side: ena/busy byte handshake supporting multi-byte writes and reads to the same slave.

Parameters:
- ADDR_W, 7, slave address width
- DATA_W, 8, data byte width; bit counter sized clog2(DATA_W)

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- data_clk  input  1  phase signal from the clock generator, synchronous to clk
- ena  input  1  transaction request / continue, sampled at data_clk rise
- addr  input  ADDR_W  slave address
- rw  input  1  0 = write, 1 = read
- data_wr  input  DATA_W  byte to write
- sda_in  input  1  sampled SDA line
- sda_drive_low  output  1  1 = pull SDA low, 0 = release
- scl_not_ena  output  1  1 = SCL released/gated, 0 = SCL toggling
- busy  output  1  transaction or byte in progress
- data_rd  output  DATA_W  last received byte
- ack_error  output  1  sticky slave NACK flag

Behaviour:
- Edge detect: data_clk_prev registered each clk. rise = data_clk & !prev; fall = !data_clk & prev. Rise and fall are mutually exclusive. State, SDA and bit changes occur only on rise; SDA sampling and SCL enable occur only on fall. All other cycles hold state.
- Reset (overrides everything, including mid-transaction):
  - state = READY, busy = 0, sda_int = 1, scl_ena = 0, bit_cnt = DATA_W-1
  - data_rd = 0, ack_error = 0, data_clk_prev = 0
  - Bus released on the first cycle after reset.
- sda_drive_low = 1 in START and STOP; otherwise !sda_int. scl_not_ena = !scl_ena.
- Latched on accept: addr_rw = {addr,rw}, data_tx = data_wr. "Same" = {addr,rw} equals addr_rw.
- Rise transitions:
  - READY: if ena, then busy = 1, latch, ack_error = 0, go to START. Else busy = 0.
  - START: sda_int = addr_rw[MSB], bit_cnt = ADDR_W, go to COMMAND.
  - COMMAND: if bit_cnt == 0, then sda_int = 1, bit_cnt = DATA_W-1, go to SLV_ACK1. Else bit_cnt--, sda_int = addr_rw[bit_cnt-1].
  - SLV_ACK1: if rw, then sda_int = 1, go to RD. Else sda_int = data_tx[MSB], go to WR.
  - WR: if bit_cnt == 0, then sda_int = 1, bit_cnt = DATA_W-1, busy = 0, go to SLV_ACK2. Else bit_cnt--, sda_int = data_tx[bit_cnt-1].
  - SLV_ACK2: if ena and same, then busy = 1, data_tx = data_wr, sda_int = data_wr[MSB], go to WR. Else go to STOP.
  - RD: if bit_cnt == 0, then data_rd = data_rx, busy = 0, bit_cnt = DATA_W-1, sda_int = 0 (ACK) if ena and same else 1 (NACK), go to MSTR_ACK. Else bit_cnt--.
  - MSTR_ACK: if ena and same, then busy = 1, sda_int = 1, go to RD. Else go to STOP.
  - STOP: busy = 0, go to READY (SDA released while SCL high gives the STOP condition).
- Fall actions:
  - START: scl_ena = 1.
  - STOP: scl_ena = 0.
  - SLV_ACK1 / SLV_ACK2: if sda_in = 1, set ack_error = 1.
  - RD: data_rx[bit_cnt] = sda_in.
- ack_error is sticky: cleared only by reset or the next READY→START. A NACK does not abort; the sequence continues per ena.
- A different address or rw on continuation always ends with STOP. No repeated start.
- ena changes between rises are ignored.

Test Plan:
- Write 0x5A to addr 0x50:
  - Stimulus: ena=1, rw=0; drop ena once busy falls; sda_in=0 during ACK slots.
  - Required: START; SDA bits 1,0,1,0,0,0,0,0 then 0,1,0,1,1,0,1,0; STOP.
  - Required: scl_not_ena 0 between START and STOP; ack_error = 0.
- Read from addr 0x23, slave returns 0xC3, ena dropped:
  - Required: data_rd = 0xC3 at MSTR_ACK entry; master NACK (sda_drive_low = 0); STOP.
- Two-byte write 0x11 then 0x22, ena held with same addr:
  - Required: busy pulses low once at SLV_ACK2 entry; second byte shifted with no START in between.
- Address NACK (sda_in = 1 in SLV_ACK1):
  - Required: ack_error = 1 and remains 1 through STOP; cleared on the next accepted ena.
- rst asserted mid-WR:
  - Required: next cycle state = READY, busy = 0, sda_drive_low = 0, scl_not_ena = 1.
- Idle with ena = 0 over 5 data_clk periods:
  - Required: busy = 0, scl_not_ena = 1, sda_drive_low = 0 throughout.
